// File: rtl/pc_generator_if.sv
// Fetch-group bus between the PC stage, the branch predictor and the I-cache.
// The PC stage takes the master side; consumers/controllers take the slave side.
interface pc_generator_if;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_target_i;
  logic        taken_or_not_1_i;
  logic        taken_or_not_2_i;
  logic [31:0] branch_target_1_i;
  logic [31:0] branch_target_2_i;
  logic [31:0] pc_1_o;
  logic [31:0] pc_2_o;
  logic        inst_en_1_o;
  logic        inst_en_2_o;
  logic        valid_o;
  logic        adef_o;

  modport master (
    input  stall_i, flush_i, flush_target_i,
    input  taken_or_not_1_i, taken_or_not_2_i, branch_target_1_i, branch_target_2_i,
    output pc_1_o, pc_2_o, inst_en_1_o, inst_en_2_o, valid_o, adef_o
  );

  modport slave (
    output stall_i, flush_i, flush_target_i,
    output taken_or_not_1_i, taken_or_not_2_i, branch_target_1_i, branch_target_2_i,
    input  pc_1_o, pc_2_o, inst_en_1_o, inst_en_2_o, valid_o, adef_o
  );
endinterface

// File: rtl/pc_generator.sv
// Front-end PC stage: selects the next dual-issue fetch group from flush, stall,
// BPU prediction or sequential advance. Outputs depend only on registered state.
module pc_generator #(
  parameter logic [31:0] RESET_PC    = 32'h1c000000,
  parameter int unsigned FETCH_BYTES = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_generator_if.master bus
);

  localparam logic [31:0] LINE_STEP = 32'(FETCH_BYTES);
  localparam logic [31:0] HALF_STEP = 32'(FETCH_BYTES / 2);

  logic [31:0] pc_q;
  logic        valid_q;
  logic        adef_q;
  logic        inst_en_1;
  logic        inst_en_2;

  always_comb begin
    inst_en_1 = valid_q & ~adef_q;
    inst_en_2 = inst_en_1 & ~pc_q[2];
  end

  always_comb begin
    bus.pc_1_o      = pc_q;
    bus.pc_2_o      = pc_q + 32'd4;
    bus.inst_en_1_o = inst_en_1;
    bus.inst_en_2_o = inst_en_2;
    bus.valid_o     = valid_q;
    bus.adef_o      = adef_q;
  end

  // The first edge after reset release only raises valid (unless a flush arrives),
  // so the group at RESET_PC is presented before any advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      adef_q  <= 1'b0;
    end else if (!valid_q) begin
      valid_q <= 1'b1;
      if (bus.flush_i) begin
        pc_q   <= bus.flush_target_i;
        adef_q <= (bus.flush_target_i[1:0] != 2'b00);
      end
    end else if (bus.flush_i) begin
      pc_q   <= bus.flush_target_i;
      adef_q <= (bus.flush_target_i[1:0] != 2'b00);
    end else if (adef_q || bus.stall_i) begin
      pc_q <= pc_q;
    end else if (bus.taken_or_not_1_i && inst_en_1) begin
      pc_q <= {bus.branch_target_1_i[31:2], 2'b00};
    end else if (bus.taken_or_not_2_i && inst_en_2) begin
      pc_q <= {bus.branch_target_2_i[31:2], 2'b00};
    end else begin
      pc_q <= pc_q + (pc_q[2] ? HALF_STEP : LINE_STEP);
    end
  end

endmodule

// File: tb/tb_pc_generator.sv
// Bench for pc_generator: directed vector table with hand-derived expectations,
// then randomized flush/stall/taken traffic against a behavioural model.
module tb_pc_generator;

  localparam logic [31:0] RP = 32'h1c000000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_generator_if bus ();

  pc_generator #(.RESET_PC(RP), .FETCH_BYTES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    logic        rst_n, stall, flush;
    logic [31:0] ftgt;
    logic        t1, t2;
    logic [31:0] bt1, bt2;
  } in_t;

  typedef struct {
    in_t         i;
    logic [31:0] e_pc;
    logic        e_valid, e_adef, e_en1, e_en2;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        valid, adef;
  } mstate_t;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  vec_t        vecs[$];
  mstate_t     m;

  function automatic in_t mk_in(logic r, logic s, logic f, logic [31:0] ft,
                                logic a1, logic [31:0] b1, logic a2, logic [31:0] b2);
    in_t x;
    x.rst_n = r; x.stall = s; x.flush = f; x.ftgt = ft;
    x.t1 = a1; x.bt1 = b1; x.t2 = a2; x.bt2 = b2;
    return x;
  endfunction

  function automatic void add(in_t x, logic [31:0] pc, logic v, logic a, logic e1, logic e2);
    vec_t w;
    w.i = x; w.e_pc = pc; w.e_valid = v; w.e_adef = a; w.e_en1 = e1; w.e_en2 = e2;
    vecs.push_back(w);
  endfunction

  // Reference behaviour: group address rules stated in terms of 8-byte fetch lines.
  function automatic mstate_t model_next(mstate_t s, in_t x);
    mstate_t n = s;
    logic slot1, slot2;
    if (!x.rst_n) begin
      n.pc = RP; n.valid = 1'b0; n.adef = 1'b0;
      return n;
    end
    if (!s.valid) begin
      n.valid = 1'b1;
      if (x.flush) begin n.pc = x.ftgt; n.adef = (x.ftgt % 4) != 0; end
      return n;
    end
    if (x.flush) begin
      n.pc = x.ftgt; n.adef = (x.ftgt % 4) != 0;
      return n;
    end
    if (s.adef || x.stall) return n;
    slot1 = 1'b1;
    slot2 = (s.pc % 8) == 0;
    if (x.t1 && slot1)      n.pc = x.bt1 - (x.bt1 % 4);
    else if (x.t2 && slot2) n.pc = x.bt2 - (x.bt2 % 4);
    else                    n.pc = (s.pc / 8 + 1) * 8;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic v,
                         input logic a, input logic e1, input logic e2);
    chk({tag, ".pc_1"},  bus.pc_1_o, pc);
    chk({tag, ".pc_2"},  bus.pc_2_o, pc + 32'd4);
    chk({tag, ".valid"}, {31'd0, bus.valid_o}, {31'd0, v});
    chk({tag, ".adef"},  {31'd0, bus.adef_o}, {31'd0, a});
    chk({tag, ".en1"},   {31'd0, bus.inst_en_1_o}, {31'd0, e1});
    chk({tag, ".en2"},   {31'd0, bus.inst_en_2_o}, {31'd0, e2});
  endtask

  task automatic apply(input in_t x);
    rst_n                 = x.rst_n;
    bus.stall_i           = x.stall;
    bus.flush_i           = x.flush;
    bus.flush_target_i    = x.ftgt;
    bus.taken_or_not_1_i  = x.t1;
    bus.taken_or_not_2_i  = x.t2;
    bus.branch_target_1_i = x.bt1;
    bus.branch_target_2_i = x.bt2;
    @(posedge clk);
    m = model_next(m, x);
    #1;
  endtask

  initial begin
    in_t idle, rst, x;
    logic [31:0] r;
    idle = mk_in(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    rst  = mk_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    m.pc = RP; m.valid = 1'b0; m.adef = 1'b0;

    // reset and sequential start
    add(rst, RP, 0, 0, 0, 0);
    add(rst, RP, 0, 0, 0, 0);
    add(rst, RP, 0, 0, 0, 0);
    add(idle, RP, 1, 0, 1, 1);
    add(idle, 32'h1c000008, 1, 0, 1, 1);
    add(idle, 32'h1c000010, 1, 0, 1, 1);
    // predictions: slot 2, then slot 1 beats slot 2
    add(mk_in(1, 0, 0, '0, 0, '0, 1, 32'h1c000800), 32'h1c000800, 1, 0, 1, 1);
    add(mk_in(1, 0, 1, 32'h1c000010, 0, '0, 0, '0), 32'h1c000010, 1, 0, 1, 1);
    add(mk_in(1, 0, 0, '0, 1, 32'h1c000400, 1, 32'h1c000800), 32'h1c000400, 1, 0, 1, 1);
    // unaligned group: slot 2 off, its taken prediction ignored
    add(mk_in(1, 0, 1, 32'h1c000104, 0, '0, 0, '0), 32'h1c000104, 1, 0, 1, 0);
    add(mk_in(1, 0, 0, '0, 0, '0, 1, 32'h1c000800), 32'h1c000108, 1, 0, 1, 1);
    // stall, flush during stall wins and then holds
    add(mk_in(1, 1, 0, '0, 0, '0, 0, '0), 32'h1c000108, 1, 0, 1, 1);
    add(mk_in(1, 1, 1, 32'h1c002000, 0, '0, 0, '0), 32'h1c002000, 1, 0, 1, 1);
    add(mk_in(1, 1, 0, '0, 1, 32'h1c000400, 0, '0), 32'h1c002000, 1, 0, 1, 1);
    add(mk_in(1, 1, 0, '0, 0, '0, 0, '0), 32'h1c002000, 1, 0, 1, 1);
    add(idle, 32'h1c002008, 1, 0, 1, 1);
    // address error holds despite predictions until a clean flush
    add(mk_in(1, 0, 1, 32'h1c000006, 0, '0, 0, '0), 32'h1c000006, 1, 1, 0, 0);
    for (int unsigned k = 0; k < 5; k++)
      add(mk_in(1, 0, 0, '0, 1, 32'h1c000400, 1, 32'h1c000800), 32'h1c000006, 1, 1, 0, 0);
    add(mk_in(1, 0, 1, 32'h1c000000, 0, '0, 0, '0), 32'h1c000000, 1, 0, 1, 1);
    add(idle, 32'h1c000008, 1, 0, 1, 1);
    // wraparound from both line halves
    add(mk_in(1, 0, 1, 32'hfffffff8, 0, '0, 0, '0), 32'hfffffff8, 1, 0, 1, 1);
    add(idle, 32'h00000000, 1, 0, 1, 1);
    add(mk_in(1, 0, 1, 32'hfffffffc, 0, '0, 0, '0), 32'hfffffffc, 1, 0, 1, 0);
    add(idle, 32'h00000000, 1, 0, 1, 1);
    // mid-stream reset beats flush; flush in first cycle after release; target masking
    add(mk_in(0, 0, 1, 32'h1c000040, 0, '0, 0, '0), RP, 0, 0, 0, 0);
    add(mk_in(1, 0, 1, 32'h1c000040, 0, '0, 0, '0), 32'h1c000040, 1, 0, 1, 1);
    add(mk_in(1, 0, 0, '0, 1, 32'h1c000333, 0, '0), 32'h1c000330, 1, 0, 1, 1);
    add(mk_in(1, 1, 0, '0, 1, 32'h1c000500, 0, '0), 32'h1c000330, 1, 0, 1, 1);

    for (int unsigned n = 0; n < vecs.size(); n++) begin
      apply(vecs[n].i);
      chk_all($sformatf("vec%0d", n), vecs[n].e_pc, vecs[n].e_valid, vecs[n].e_adef,
              vecs[n].e_en1, vecs[n].e_en2);
    end

    apply(rst);
    apply(rst);
    for (int unsigned n = 0; n < 600; n++) begin
      x = idle;
      x.rst_n = ($urandom_range(99) >= 2);
      x.stall = ($urandom_range(3) == 0);
      x.flush = ($urandom_range(99) < 12);
      r = $urandom();
      if ($urandom_range(3) != 0) r[1:0] = 2'b00;
      if ($urandom_range(7) == 0) r = 32'hfffffff0 | (r & 32'hc);
      x.ftgt = r;
      x.t1  = ($urandom_range(9) < 3);
      x.t2  = ($urandom_range(9) < 3);
      x.bt1 = $urandom();
      x.bt2 = $urandom();
      apply(x);
      chk_all($sformatf("rnd%0d", n), m.pc, m.valid, m.adef, m.valid & ~m.adef,
              m.valid & ~m.adef & ((m.pc % 8) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
